// File: rtl/dm_cache_if.sv
// Command/result bus of the direct-mapped cache; names follow the cache's point of view.
interface dm_cache_if #(
  parameter int DataWidth     = 8,
  parameter int AddrWidth     = 8,
  parameter int ExtraTagWidth = 4
);
  logic                     o_ready;
  logic                     i_enable;
  logic [1:0]               i_cmd;
  logic [AddrWidth-1:0]     i_addr;
  logic [DataWidth-1:0]     i_din;
  logic [ExtraTagWidth-1:0] i_extra_tag;
  logic                     o_out_valid;
  logic                     o_hit;
  logic [DataWidth-1:0]     o_dout;
  logic                     o_refill_data_ready;
  logic                     o_evicting;
  logic [AddrWidth-1:0]     o_addr_out;
  logic [ExtraTagWidth-1:0] o_extra_tag;

  modport master (
    input  o_ready, o_out_valid, o_hit, o_dout, o_refill_data_ready, o_evicting,
           o_addr_out, o_extra_tag,
    output i_enable, i_cmd, i_addr, i_din, i_extra_tag
  );

  modport slave (
    output o_ready, o_out_valid, o_hit, o_dout, o_refill_data_ready, o_evicting,
           o_addr_out, o_extra_tag,
    input  i_enable, i_cmd, i_addr, i_din, i_extra_tag
  );
endinterface

// File: rtl/dm_cache.sv
// Direct-mapped cache with streamed line refill and eviction readout.
// Optional hit/miss counters are built when DM_CACHE_PERF_EN is defined.
//
// state   | meaning
// ST_INIT | first cycle out of reset, not ready
// ST_IDLE | ready for read/write/refill commands
// ST_FILL | refill words 1..N-1 being streamed in
// ST_DONE | refill result pulse; line becomes valid on exit
module dm_cache #(
  parameter int DataWidth     = 8,
  parameter int LogLineSize   = 2,
  parameter int Capacity      = 16,
  parameter int AddrWidth     = 8,
  parameter int ExtraTagWidth = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  dm_cache_if.slave   bus
`ifdef DM_CACHE_PERF_EN
  ,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
`endif
);
  localparam int LineWords = 1 << LogLineSize;
  localparam int Lines     = Capacity / LineWords;
  localparam int WordW     = (Capacity > 1) ? $clog2(Capacity) : 1;
  localparam int IdxW      = (Lines > 1) ? $clog2(Lines) : 1;
  localparam int CntW      = LogLineSize + 1;
  localparam logic [AddrWidth-1:0] LowMask = AddrWidth'(Capacity - 1);
  localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(LineWords - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FILL, ST_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [DataWidth-1:0]     r_data [Capacity];
  logic [AddrWidth-1:0]     r_tag  [Lines];
  logic [ExtraTagWidth-1:0] r_etag [Lines];
  logic [Lines-1:0]         r_valid;

  logic [IdxW-1:0]          r_fill_idx;
  logic [WordW-1:0]         r_fill_word;
  logic [AddrWidth-1:0]     r_fill_tag;
  logic [ExtraTagWidth-1:0] r_fill_etag;
  logic                     r_fill_evict;
  logic [CntW-1:0]          r_left;

  logic                     r_out_valid, r_hit, r_evicting;
  logic [DataWidth-1:0]     r_dout;
  logic [AddrWidth-1:0]     r_addr_out;
  logic [ExtraTagWidth-1:0] r_etag_out;

  logic                 w_ready, w_fill, w_accept, w_is_write, w_is_refill, w_lookup;
  logic                 w_hit, w_displace, w_strobe, w_strobe_evict, w_last;
  logic [AddrWidth-1:0] w_tag_part, w_resident_addr;
  logic [IdxW-1:0]      w_idx, w_cur_idx;
  logic [WordW-1:0]     w_word, w_base_word, w_strobe_word;

  // Tags are stored in place (index/offset bits zeroed) so no zero-width fields arise.
  assign w_tag_part  = bus.i_addr & ~LowMask;
  assign w_idx       = IdxW'((bus.i_addr & LowMask) >> LogLineSize);
  assign w_word      = WordW'(bus.i_addr & LowMask);
  assign w_base_word = WordW'(bus.i_addr & LowMask & ~OffMask);

  assign w_ready     = (r_state == ST_IDLE);
  assign w_fill      = (r_state == ST_FILL);
  assign w_accept    = w_ready & bus.i_enable;
  assign w_is_write  = (bus.i_cmd == 2'b00);
  assign w_is_refill = (bus.i_cmd == 2'b10);
  assign w_lookup    = w_accept & ~w_is_refill;
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag_part);
  assign w_displace  = r_valid[w_idx] && (r_tag[w_idx] != w_tag_part);

  assign w_strobe       = (w_accept & w_is_refill) | (w_fill & bus.i_enable);
  assign w_strobe_word  = w_fill ? r_fill_word : w_base_word;
  assign w_strobe_evict = w_fill ? r_fill_evict : w_displace;
  assign w_last         = w_fill ? (r_left == CntW'(1)) : (LineWords == 1);
  assign w_cur_idx      = w_fill ? r_fill_idx : w_idx;
  assign w_resident_addr = r_tag[w_cur_idx] | (AddrWidth'(w_cur_idx) << LogLineSize);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: w_state_nxt = ST_IDLE;
      ST_IDLE: if (w_accept && w_is_refill) w_state_nxt = (LineWords == 1) ? ST_DONE : ST_FILL;
      ST_FILL: if (bus.i_enable && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < Capacity; i++) r_data[i] <= '0;
      for (int i = 0; i < Lines; i++) begin
        r_tag[i]  <= '0;
        r_etag[i] <= '0;
      end
      r_fill_idx   <= '0;
      r_fill_word  <= '0;
      r_fill_tag   <= '0;
      r_fill_etag  <= '0;
      r_fill_evict <= 1'b0;
      r_left       <= '0;
      r_out_valid  <= 1'b0;
      r_hit        <= 1'b0;
      r_evicting   <= 1'b0;
      r_dout       <= '0;
      r_addr_out   <= '0;
      r_etag_out   <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_evicting  <= 1'b0;
      if (w_lookup) begin
        r_out_valid <= 1'b1;
        r_hit       <= w_hit;
        r_dout      <= r_data[w_word];
        r_addr_out  <= w_resident_addr;
        r_etag_out  <= r_etag[w_idx];
        if (w_is_write && w_hit) r_data[w_word] <= bus.i_din;
      end
      if (w_accept && w_is_refill) begin
        r_fill_idx   <= w_idx;
        r_fill_word  <= w_base_word + WordW'(1);
        r_fill_tag   <= w_tag_part;
        r_fill_etag  <= bus.i_extra_tag;
        r_fill_evict <= w_displace;
        r_left       <= CntW'(LineWords - 1);
      end
      if (w_fill && bus.i_enable) begin
        r_fill_word <= r_fill_word + WordW'(1);
        r_left      <= r_left - CntW'(1);
      end
      // Old word is read out on the same edge the new word lands.
      if (w_strobe) begin
        r_data[w_strobe_word] <= bus.i_din;
        if (w_strobe_evict) begin
          r_evicting <= 1'b1;
          r_dout     <= r_data[w_strobe_word];
        end
        if (w_last) begin
          r_out_valid <= 1'b1;
          r_hit       <= 1'b0;
          r_addr_out  <= w_resident_addr;
          r_etag_out  <= r_etag[w_cur_idx];
        end
      end
      if (r_state == ST_DONE) begin
        r_valid[r_fill_idx] <= 1'b1;
        r_tag[r_fill_idx]   <= r_fill_tag;
        r_etag[r_fill_idx]  <= r_fill_etag;
      end
    end
  end

  assign bus.o_ready             = w_ready;
  assign bus.o_refill_data_ready = w_fill;
  assign bus.o_out_valid         = r_out_valid;
  assign bus.o_hit               = r_hit;
  assign bus.o_evicting          = r_evicting;
  assign bus.o_dout              = r_dout;
  assign bus.o_addr_out          = r_addr_out;
  assign bus.o_extra_tag         = r_etag_out;

`ifdef DM_CACHE_PERF_EN
  logic [31:0] r_hit_count, r_miss_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_lookup) begin
      if (w_hit) begin
        if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
      end else if (r_miss_count != '1) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_dm_cache.sv
// Randomized bench for dm_cache against a behavioural line/word model, plus literal scenarios.
module tb_dm_cache;
  localparam int N = 4, CAP = 16, LINES = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_cache_if #(.DataWidth(8), .AddrWidth(8), .ExtraTagWidth(4)) bus ();
`ifdef DM_CACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  dm_cache #(.DataWidth(8), .LogLineSize(2), .Capacity(16), .AddrWidth(8),
             .ExtraTagWidth(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
`ifdef DM_CACHE_PERF_EN
    , .o_hit_count(hit_count), .o_miss_count(miss_count)
`endif
  );

  int n_checks = 0, n_pass = 0;

  // model state
  bit m_valid[LINES];
  int m_tag[LINES], m_etag[LINES], m_data[CAP];
  bit f_active, f_done, f_evict;
  int f_line, f_base, f_tag, f_etag, f_cnt;
  bit e_ready, e_rdr, e_ov, e_ev, e_hit, k_dout, k_addr;
  int e_dout, e_addr, e_etag, m_hits, m_misses;

  // inputs of the current cycle
  bit d_ena;
  logic [1:0] d_cmd;
  logic [7:0] d_addr, d_din;
  logic [3:0] d_et;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function void model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    f_active = 0; f_done = 0;
    e_ready = 0; e_rdr = 0; e_ov = 0; e_ev = 0; e_hit = 0;
    e_dout = 0; e_addr = 0; e_etag = 0; k_dout = 1; k_addr = 1;
    m_hits = 0; m_misses = 0;
  endfunction

  function void fill_word();
    int w;
    w = (f_base % CAP) + f_cnt;
    if (f_evict) begin
      e_ev = 1; e_dout = m_data[w]; k_dout = 1;
    end
    m_data[w] = int'(d_din);
    f_cnt++;
    if (f_cnt == N) begin
      f_active = 0; f_done = 1; e_rdr = 0; e_ov = 1; e_hit = 0;
      k_addr = m_valid[f_line];
      e_addr = m_tag[f_line] * CAP + f_line * N;
      e_etag = m_etag[f_line];
    end
  endfunction

  function void model_step();
    int line, tag, a;
    bit hit;
    e_ov = 0; e_ev = 0;
    a = int'(d_addr);
    line = (a % CAP) / N;
    tag = a / CAP;
    if (f_done) begin
      f_done = 0; m_valid[f_line] = 1; m_tag[f_line] = f_tag; m_etag[f_line] = f_etag;
      e_ready = 1;
    end else if (f_active) begin
      if (d_ena) fill_word();
    end else if (!e_ready) begin
      e_ready = 1;
    end else if (d_ena) begin
      if (d_cmd == 2'b10) begin
        f_active = 1; f_line = line; f_base = a; f_tag = tag; f_etag = int'(d_et); f_cnt = 0;
        f_evict = m_valid[line] && (m_tag[line] != tag);
        e_ready = 0; e_rdr = 1;
        fill_word();
      end else begin
        hit = m_valid[line] && (m_tag[line] == tag);
        e_ov = 1; e_hit = hit;
        k_dout = m_valid[line]; k_addr = m_valid[line];
        e_dout = m_data[a % CAP];
        e_addr = m_tag[line] * CAP + line * N;
        e_etag = m_etag[line];
        if (hit) m_hits++; else m_misses++;
        if (hit && d_cmd == 2'b00) m_data[a % CAP] = int'(d_din);
      end
    end
  endfunction

  always @(negedge clk) begin
    check("ready", bus.o_ready, e_ready);
    check("refill_data_ready", bus.o_refill_data_ready, e_rdr);
    check("out_valid", bus.o_out_valid, e_ov);
    check("evicting", bus.o_evicting, e_ev);
    check("hit", bus.o_hit, e_hit);
    if (k_dout) check("dout", bus.o_dout, e_dout);
    if (k_addr) begin
      check("addr_out", bus.o_addr_out, e_addr);
      check("extra_tag_out", bus.o_extra_tag, e_etag);
    end
`ifdef DM_CACHE_PERF_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif
  end

  task automatic do_cycle(input bit ena, input logic [1:0] cmd, input logic [7:0] addr,
                          input logic [7:0] din, input logic [3:0] et);
    d_ena = ena; d_cmd = cmd; d_addr = addr; d_din = din; d_et = et;
    bus.i_enable = ena; bus.i_cmd = cmd; bus.i_addr = addr; bus.i_din = din;
    bus.i_extra_tag = et;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    d_ena = 0; bus.i_enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    do_cycle(0, 2'b01, 8'h00, 8'h00, 4'h0);
  endtask

  initial begin
    int low;
    logic [7:0] ev_d[4];
    logic [7:0] words[4];
    bit ev_all;
    rst_n = 1'b0;
    bus.i_enable = 1'b0; bus.i_cmd = 2'b01; bus.i_addr = '0; bus.i_din = '0;
    bus.i_extra_tag = '0;
    for (int i = 0; i < CAP; i++) m_data[i] = 0;
    for (int i = 0; i < LINES; i++) begin m_tag[i] = 0; m_etag[i] = 0; end
    model_reset();
    reset_pulse();
    check("ready_after_reset", bus.o_ready, 1);

    do_cycle(1, 2'b01, 8'h05, 8'h00, 4'h0);
    check("rd05_ov", bus.o_out_valid, 1);
    check("rd05_hit", bus.o_hit, 0);
    check("rd05_ready", bus.o_ready, 1);

    words[0] = 8'hAA; words[1] = 8'hBB; words[2] = 8'hCC; words[3] = 8'hDD;
    low = 0; ev_all = 0;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1, (i == 0) ? 2'b10 : 2'b01, 8'h04, words[i], 4'h3);
      if (!bus.o_ready) low++;
      if (bus.o_evicting) ev_all = 1;
    end
    check("fill04_ov", bus.o_out_valid, 1);
    check("fill04_hit", bus.o_hit, 0);
    do_cycle(0, 2'b01, 8'h00, 8'h00, 4'h0);
    check("fill04_ready_back", bus.o_ready, 1);
    check("fill04_low_cycles", low, 4);
    check("fill04_no_evict", ev_all, 0);

    do_cycle(1, 2'b01, 8'h06, 8'h00, 4'h0);
    check("rd06_hit", bus.o_hit, 1);
    check("rd06_dout", bus.o_dout, 8'hCC);
    check("rd06_etag", bus.o_extra_tag, 3);

    do_cycle(1, 2'b00, 8'h05, 8'h55, 4'h0);
    check("wr05_hit", bus.o_hit, 1);
    check("wr05_old", bus.o_dout, 8'hBB);
    do_cycle(1, 2'b11, 8'h05, 8'h00, 4'h0);
    check("rd05_new", bus.o_dout, 8'h55);

    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    ev_all = 1;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1, (i == 0) ? 2'b10 : 2'b00, 8'h14, words[i], 4'h5);
      ev_d[i] = bus.o_dout;
      if (!bus.o_evicting) ev_all = 0;
    end
    check("fill14_evicting", ev_all, 1);
    check("fill14_ev0", ev_d[0], 8'hAA);
    check("fill14_ev1", ev_d[1], 8'h55);
    check("fill14_ev2", ev_d[2], 8'hCC);
    check("fill14_ev3", ev_d[3], 8'hDD);
    check("fill14_addr_out", bus.o_addr_out, 8'h04);
    check("fill14_etag_out", bus.o_extra_tag, 3);
    do_cycle(0, 2'b01, 8'h00, 8'h00, 4'h0);

    // reset while the third word of a refill is being presented
    do_cycle(1, 2'b10, 8'h24, 8'h01, 4'h7);
    do_cycle(1, 2'b01, 8'h00, 8'h02, 4'h0);
    bus.i_enable = 1'b1; bus.i_din = 8'h03; d_ena = 1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ov", bus.o_out_valid, 0);
    check("rst_hit", bus.o_hit, 0);
    check("rst_evicting", bus.o_evicting, 0);
    check("rst_rdr", bus.o_refill_data_ready, 0);
    check("rst_dout", bus.o_dout, 0);
    check("rst_addr_out", bus.o_addr_out, 0);
    check("rst_etag_out", bus.o_extra_tag, 0);
    bus.i_enable = 1'b0; d_ena = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    do_cycle(0, 2'b01, 8'h00, 8'h00, 4'h0);
    do_cycle(1, 2'b01, 8'h24, 8'h00, 4'h0);
    check("after_abort_hit", bus.o_hit, 0);
    do_cycle(1, 2'b01, 8'h14, 8'h00, 4'h0);
    check("after_abort_old_hit", bus.o_hit, 0);

    for (int c = 0; c < 4000; c++) begin
      logic [1:0] cmd;
      logic [7:0] a;
      bit ena;
      cmd = 2'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 63));
      if (e_ready && cmd == 2'b10) a = a & 8'hFC;
      ena = ($urandom_range(0, 3) != 0);
      do_cycle(ena, cmd, a, 8'($urandom), 4'($urandom));
    end

`ifdef DM_CACHE_PERF_EN
    reset_pulse();
    check("perf_hit_zero", hit_count, 0);
    check("perf_miss_zero", miss_count, 0);
    for (int i = 0; i < 4; i++) do_cycle(1, (i == 0) ? 2'b10 : 2'b01, 8'h00, 8'(i), 4'h1);
    do_cycle(0, 2'b01, 8'h00, 8'h00, 4'h0);
    do_cycle(1, 2'b01, 8'h00, 8'h00, 4'h0);
    do_cycle(1, 2'b00, 8'h01, 8'h09, 4'h0);
    do_cycle(1, 2'b11, 8'h02, 8'h00, 4'h0);
    do_cycle(1, 2'b01, 8'h40, 8'h00, 4'h0);
    do_cycle(1, 2'b01, 8'h20, 8'h00, 4'h0);
    check("perf_hits3", hit_count, 3);
    check("perf_misses2", miss_count, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 SHALL have parameters: DataWidth (default 8, word width); LogLineSize (default 2, log2 words per line); Capacity (default 16, total words, power of two, at least 2^LogLineSize); AddrWidth (default 8, word address width); ExtraTagWidth (default 4, per-line side tag width).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Clock  in  1  rising-edge clock.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 Ready  out  1  command may be accepted.
REQ-006 Enable  in  1  command or refill-word strobe.
REQ-007 Cmd  in  2  00 write, 01 read, 10 refill, 11 treated as read.
REQ-008 AddrIn  in  AddrWidth  word address.
REQ-009 DIn  in  DataWidth  write or refill word.
REQ-010 ExtraTagIn  in  ExtraTagWidth  side tag stored on refill.
REQ-011 OutValid  out  1  one-cycle result pulse.
REQ-012 Hit  out  1  lookup hit.
REQ-013 DOut  out  DataWidth  resident word or evicted word.
REQ-014 RefillDataReady  out  1  refill words 1..N-1 may be supplied.
REQ-015 Evicting  out  1  DOut carries a displaced word.
REQ-016 AddrOut  out  AddrWidth  base address of the resident line at the indexed slot.
REQ-017 ExtraTagOut  out  ExtraTagWidth  side tag of the resident line.

Function
REQ-018 SHALL be direct-mapped: N = 2^LogLineSize words per line; Capacity/N lines; address fields are {tag, index, offset} from MSB to LSB.
REQ-019 A command SHALL be accepted on a rising edge with Ready and Enable both high.
REQ-020 Read: OutValid SHALL pulse on the next cycle; Hit = valid and tag match; DOut = stored word. No state change occurs.
REQ-021 Write: same timing as read. On a hit, DIn is stored and DOut returns the old word. On a miss, nothing is stored.
REQ-022 Read and write SHALL leave Ready high, so back-to-back commands are allowed.
REQ-023 Refill SHALL accept word 0 with the command. AddrIn is the line-aligned base address. ExtraTagIn and the tag are latched at this point.
REQ-024 While a refill is in progress, Ready SHALL be low and RefillDataReady high. Each Enable strobe writes the next word in order, and Cmd is ignored.
REQ-025 If the displaced line is valid with a different tag, then in the cycle after word i is written: DOut = old word i, Evicting = 1.
REQ-026 After the last word: OutValid pulses for one cycle with Hit = 0. AddrOut and ExtraTagOut carry the displaced line's values. Evicting is as in REQ-025.
REQ-027 Ready returns high on the cycle after the OutValid pulse. The line becomes valid at that point.
REQ-028 Refilling an invalid slot, or a slot with the same tag, SHALL set Evicting = 0 throughout.
REQ-029 With LogLineSize = 0, a refill SHALL complete in the single accepted cycle.
REQ-030 Outputs other than OutValid and Evicting SHALL hold their last value between pulses.

Reset
REQ-031 Reset low SHALL asynchronously clear all line valid bits and force the outputs to: OutValid 0, Hit 0, Evicting 0, RefillDataReady 0, DOut 0, AddrOut 0, ExtraTagOut 0.
REQ-032 Ready SHALL be 1 from the first edge after reset is released.
REQ-033 Reset during a refill SHALL abort the refill and leave the line invalid.

Configuration
REQ-034 With DM_CACHE_PERF_EN defined, the block SHALL add two outputs, HitCount and MissCount (32 bits each, saturating, cleared by reset), counting read/write lookups by outcome.
REQ-035 Without DM_CACHE_PERF_EN, these ports and counters SHALL be absent.

Verification
REQ-036 After reset, read 0x05 -> OutValid one cycle later with Hit 0; Ready stays 1.
REQ-037 Refill at 0x04 with words AA, BB, CC, DD and ExtraTag 3 -> Ready low for 4 cycles, no Evicting, then OutValid with Hit 0. A subsequent read of 0x06 gives Hit 1, DOut CC, ExtraTagOut 3.
REQ-038 Write 0x55 to 0x05 -> DOut BB, Hit 1. A subsequent read of 0x05 gives DOut 55.
REQ-039 Refill at 0x14 with 11, 22, 33, 44 -> Evicting over 4 cycles with DOut AA, 55, CC, DD; final OutValid with AddrOut 0x04 and ExtraTagOut 3.
REQ-040 Reset asserted during the third word of a refill -> all outputs 0 immediately. After release, a read of that line gives Hit 0.
REQ-041 With DM_CACHE_PERF_EN defined, 3 hits and 2 misses -> HitCount 3, MissCount 2.
